pipe_mem_stage: RTL
===================

// Module: pipe_mem_stage
// PURPOSE
// MEM stage of the 5-stage pipeline. It holds the EXE/MEM pipeline register and consumes
// EXE_alu (address or result), EXE_b (store data) and EXE_reg_w_num from the execute stage.
// A request/ready FSM accesses external data memory and stalls upstream stages while an
// access is outstanding. It presents registered results to the MEM/WB register.
// PARAMETERS
// TIMEOUT     16  cycles in ACCESS without mem_ready before the access aborts (legal 2..255)
// ALIGN_CHK   1   1 = misaligned word address (addr[1:0]!=0) aborts the access; 0 = no check
// PORTS
// clock          in   1   pipeline clock; all state updates on rising edge
// resetn         in   1   asynchronous, active-low reset
// EXE_alu        in   32  ALU result / effective address from EXE
// EXE_b          in   32  store data from EXE
// EXE_reg_w_num  in   5   destination register number
// EXE_wreg       in   1   instruction writes the register file
// EXE_m2reg      in   1   load: write-back value comes from memory
// EXE_wmem       in   1   store
// EXE_valid      in   1   EXE slot holds a real instruction (0 = bubble)
// mem_ready      in   1   memory completes current request this cycle
// mem_rdata      in   32  load data; valid when mem_ready=1
// mem_req        out  1   access request; high for every cycle in ACCESS
// mem_we         out  1   write strobe = mem_req & slot_wmem
// mem_addr       out  32  slot ALU value, held constant while mem_req=1
// mem_wdata      out  32  slot store data, held constant while mem_req=1
// MEM_stall      out  1   freeze PC/IF/ID/EXE registers; = (state==ACCESS)
// MEM_valid      out  1   slot result is final this cycle; = slot_valid & (state==IDLE)
// MEM_alu        out  32  registered slot ALU value
// MEM_mdata      out  32  registered load data
// MEM_reg_w_num  out  5   registered destination
// MEM_wreg       out  1   registered wreg; forced 0 when MEM_bus_err=1
// MEM_m2reg      out  1   registered m2reg
// MEM_bus_err    out  1   slot access aborted by timeout or misalignment
// BEHAVIOUR
// - Reset (async, resetn=0): state=IDLE, slot_valid=0, all MEM_* outputs=0, mem_req=0,
//   mem_we=0, timeout counter=0. mem_req drops immediately, mid-access included; no completion.
// - Capture: at an edge with MEM_stall=0, slot <= EXE_* inputs, slot_valid <= EXE_valid,
//   MEM_mdata <= 0, err <= 0. EXE_valid=0 loads a bubble: no access, MEM_valid=0 next cycle.
// - States: IDLE, ACCESS.
//   IDLE -> ACCESS: capture of valid (m2reg|wmem) op with aligned address (or ALIGN_CHK=0).
//   IDLE -> IDLE: non-memory op, bubble, or misaligned mem op. Misaligned op sets err=1 and
//     issues no request.
//   ACCESS -> IDLE: mem_ready=1. MEM_mdata <= mem_rdata for a load; a store leaves it 0.
//   ACCESS -> IDLE: counter reaches TIMEOUT-1 with mem_ready=0. err=1, nothing written.
//   ACCESS -> ACCESS: otherwise; counter increments. Counter clears on ACCESS entry.
// - Latency: a non-memory op is MEM_valid the cycle after capture, giving 1 instr/cycle.
//   A memory op with N wait cycles (mem_ready high in the (N+1)th ACCESS cycle) is
//   MEM_valid N+2 cycles after capture. The minimum is 2, with 1 stall cycle.
// - mem_ready outside ACCESS is ignored. mem_ready=1 and timeout in the same cycle counts
//   as completion, not an error.
// - Slot registers hold during ACCESS. Upstream must hold EXE_* while MEM_stall=1.
// - MEM_valid is high exactly one cycle per instruction unless the next capture is a
//   non-memory op, in which case it stays high across back-to-back instructions.
// TESTING
// - ALU op: alu=0x1234, wreg=1, rd=5 -> next cycle MEM_valid=1, MEM_alu=0x1234,
//   MEM_reg_w_num=5, stall=0.
// - Zero-wait load: addr=0x100, ready=1 in first ACCESS cycle, rdata=0xDEADBEEF ->
//   1 stall cycle, then MEM_valid=1, MEM_mdata=0xDEADBEEF.
// - Store, ready after 3 waits: addr=0x40, b=0xA5A5 -> mem_req=mem_we=1 for 4 cycles,
//   addr/wdata stable, MEM_valid 5 cycles after capture.
// - Timeout: load, mem_ready=0 forever -> mem_req high 16 cycles, then MEM_bus_err=1,
//   MEM_wreg=0, stall released.
// - Misaligned: load at 0x102 -> mem_req never asserts, next cycle MEM_bus_err=1,
//   MEM_wreg=0; with ALIGN_CHK=0 the normal access proceeds.
// - Reset mid-ACCESS (cycle 2 of a wait): resetn=0 -> mem_req=0 immediately, MEM_valid=0.
//   After release, the next ALU op completes in 1 cycle.

Source files
------------

// File: rtl/pipe_mem_stage.sv
// MEM stage of the 5-stage pipeline: EXE/MEM slot register plus a request/ready
// handshake to data memory that stalls upstream stages while an access is outstanding.
module pipe_mem_stage #(
  parameter int unsigned TIMEOUT   = 16,
  parameter bit          ALIGN_CHK = 1'b1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] EXE_alu,
  input  logic [31:0] EXE_b,
  input  logic [4:0]  EXE_reg_w_num,
  input  logic        EXE_wreg,
  input  logic        EXE_m2reg,
  input  logic        EXE_wmem,
  input  logic        EXE_valid,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        MEM_stall,
  output logic        MEM_valid,
  output logic [31:0] MEM_alu,
  output logic [31:0] MEM_mdata,
  output logic [4:0]  MEM_reg_w_num,
  output logic        MEM_wreg,
  output logic        MEM_m2reg,
  output logic        MEM_bus_err
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic        wreg_q, wreg_d;
  logic        m2reg_q, m2reg_d;
  logic        wmem_q, wmem_d;
  logic [31:0] mdata_q, mdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  // State and slot registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      alu_q   <= 32'h0;
      b_q     <= 32'h0;
      rd_q    <= 5'd0;
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      wmem_q  <= 1'b0;
      mdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      alu_q   <= alu_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      wreg_q  <= wreg_d;
      m2reg_q <= m2reg_d;
      wmem_q  <= wmem_d;
      mdata_q <= mdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and slot update: capture in IDLE, hold and count in ACCESS
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    alu_d   = alu_q;
    b_d     = b_q;
    rd_d    = rd_q;
    wreg_d  = wreg_q;
    m2reg_d = m2reg_q;
    wmem_d  = wmem_q;
    mdata_d = mdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        valid_d = EXE_valid;
        alu_d   = EXE_alu;
        b_d     = EXE_b;
        rd_d    = EXE_reg_w_num;
        wreg_d  = EXE_wreg;
        m2reg_d = EXE_m2reg;
        wmem_d  = EXE_wmem;
        mdata_d = 32'h0;
        err_d   = 1'b0;
        if (EXE_valid && (EXE_m2reg || EXE_wmem)) begin
          // A misaligned word access is rejected without ever touching memory
          if (ALIGN_CHK && (EXE_alu[1:0] != 2'b00)) begin
            err_d = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = 8'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Completion wins over timeout when both land in the same cycle
        if (mem_ready) begin
          state_d = IDLE;
          mdata_d = m2reg_q ? mem_rdata : 32'h0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_req       = (state_q == ACCESS);
  assign mem_we        = (state_q == ACCESS) & wmem_q;
  assign mem_addr      = alu_q;
  assign mem_wdata     = b_q;
  assign MEM_stall     = (state_q == ACCESS);
  assign MEM_valid     = valid_q & (state_q == IDLE);
  assign MEM_alu       = alu_q;
  assign MEM_mdata     = mdata_q;
  assign MEM_reg_w_num = rd_q;
  assign MEM_wreg      = wreg_q & ~err_q;
  assign MEM_m2reg     = m2reg_q;
  assign MEM_bus_err   = err_q;

endmodule
